data_fifo: RTL and testbench
============================

DATA_FIFO -- requirements
Module: data_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of 32-bit storage entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 data_in  input  32  unsigned word from the upstream register stage.
REQ-006 in_valid  input  1  data_in carries a word this cycle.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 data_out  output  32  head-of-queue word.
REQ-009 out_valid  output  1  data_out holds a valid word.
REQ-010 out_ready  input  1  consumer takes data_out this cycle.
REQ-011 count  output  CNT_W  current number of stored words, 0..DEPTH.
REQ-012 drop_err  output  1  sticky flag: a word was offered while full.

Function
REQ-013 A push SHALL occur on a posedge where in_valid=1 and in_ready=1; data_in is written at the tail.
REQ-014 A pop SHALL occur on a posedge where out_valid=1 and out_ready=1; the head advances.
REQ-015 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-016 out_valid SHALL equal (count != 0); data_out SHALL be the head word (first-word fall-through).
REQ-017 A word pushed at edge N SHALL be on data_out with out_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-018 Words SHALL leave in arrival order, with no duplication or loss of accepted words.
REQ-019 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-020 When full, a simultaneous pop SHALL NOT enable a push that cycle; the push is refused.
REQ-021 When empty, a push SHALL be accepted and no pop SHALL occur, regardless of out_ready.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-023 count SHALL increment on push-only, decrement on pop-only, and hold otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-024 drop_err SHALL set on the posedge after in_valid=1 with in_ready=0 and stay set until reset.
REQ-025 data_out SHALL be 0 whenever out_valid=0.

Reset
REQ-026 While reset=1 at a posedge: pointers=0, count=0, drop_err=0, in_ready=1, out_valid=0, data_out=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; no push or pop SHALL take effect on that edge.
REQ-028 Storage array contents need not be cleared by reset.
REQ-029 The first push SHALL be accepted on the first posedge after reset deasserts.

Structure
REQ-030 Package data_fifo_pkg SHALL hold DEPTH_DEFAULT=8, WORD_W=32, and typedef word_t (32-bit unsigned), shared with the upstream stage and the testbench.
REQ-031 Storage SHALL be one sub-module, data_fifo_mem: a DEPTH x 32 array with one synchronous write port and one combinational read port.
REQ-032 Pointer, count and flag logic SHALL stay in data_fifo.

Verification
REQ-033 Reset, then push 5,6,7 with out_ready=0 -> count=3, data_out=5; then out_ready=1 -> data_out sequence 5,6,7, then out_valid=0, count=0.
REQ-034 Push 8 words 100..107 with out_ready=0 -> in_ready=0, count=8; offer 200 -> drop_err=1 next cycle, 200 never appears at data_out.
REQ-035 Full FIFO, in_valid=1 with data 300, out_ready=1 for one cycle -> 100 popped, 300 not accepted, count=7.
REQ-036 Continuous push 1..20 with out_ready=1 from count=2 -> count stays 2, outputs 1..20 in order (exercises pointer wrap).
REQ-037 Load 4 words, assert reset for one cycle mid-stream -> count=0, out_valid=0, data_out=0, drop_err=0; next push 42 appears as head.
REQ-038 Empty FIFO, out_ready=1 held, push 9 -> count=1 after the edge, out_valid=1 with data_out=9 in the following cycle, pop on the next edge.

Source files
------------

// File: rtl/data_fifo_pkg.sv
// rtl/data_fifo_pkg.sv - shared word type and defaults for the data FIFO
package data_fifo_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int WORD_W        = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Per-edge activity, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/data_fifo_mem.sv
// rtl/data_fifo_mem.sv - DEPTH x WORD_W storage, sync write, combinational read
module data_fifo_mem
    import data_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    word_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/data_fifo.sv
// rtl/data_fifo.sv - first-word fall-through FIFO with occupancy count and sticky drop flag
module data_fifo
    import data_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              drop_err
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_drop_err;

    logic             w_push;
    logic             w_pop;
    fifo_op_e         w_op;
    word_t            w_rd_data;

    // in_ready comes only from stored state, so a pop cannot free a slot for the same edge
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_op      = fifo_op_e'({w_push, w_pop});

    assign data_out  = out_valid ? w_rd_data : '0;
    assign count     = r_count;
    assign drop_err  = r_drop_err;

    data_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_push && !reset),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case (w_op)
                OP_PUSH: r_count <= r_count + CNT_W'(1);
                OP_POP:  r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (in_valid && !in_ready) begin
                r_drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_fifo.sv
// tb/tb_data_fifo.sv - scoreboard bench for data_fifo with directed and random traffic
module tb_data_fifo;
    import data_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [WORD_W-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              drop_err;

    always #5 clk = ~clk;

    data_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .drop_err  (drop_err)
    );

    int    n_vec = 0;
    int    n_err = 0;
    word_t exp_q[$];
    int    m_count = 0;
    bit    m_drop  = 1'b0;
    bit    m_acc;
    bit    m_pop;
    bit    mon_en  = 1'b0;
    word_t w_dummy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words plus an occupancy number
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_count = 0;
            m_drop  = 1'b0;
        end else begin
            m_acc = in_valid && (m_count < DEPTH);
            m_pop = out_ready && (m_count > 0);
            if (in_valid && m_count == DEPTH) m_drop = 1'b1;
            if (m_acc) exp_q.push_back(data_in);
            m_count = m_count + int'(m_acc) - int'(m_pop);
        end
    end

    // Monitor: compares visible state mid-cycle and retires the head when it is consumed
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 32'(count), 32'(m_count));
            check("in_ready", 32'(in_ready), 32'(m_count != DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_count != 0));
            check("drop_err", 32'(drop_err), 32'(m_drop));
            if (m_count != 0 && exp_q.size() != 0) begin
                check("data_out", data_out, exp_q[0]);
                if (out_ready && !reset) w_dummy = exp_q.pop_front();
            end else begin
                check("data_out_idle", data_out, 32'd0);
            end
        end
    end

    task automatic cyc(input bit v, input word_t d, input bit r);
        in_valid  = v;
        data_in   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        reset = 1'b0;

        cyc(1, 5, 0); cyc(1, 6, 0); cyc(1, 7, 0);
        check("three_count", 32'(count), 32'd3);
        check("three_head", data_out, 32'd5);
        repeat (3) cyc(0, 0, 1);
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_count", 32'(count), 32'd0);

        for (int i = 0; i < 8; i++) cyc(1, word_t'(100 + i), 0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd8);
        cyc(1, 200, 0);
        check("drop_set", 32'(drop_err), 32'd1);
        check("drop_count", 32'(count), 32'd8);
        cyc(1, 300, 1);
        check("full_pop_count", 32'(count), 32'd7);
        check("full_pop_head", data_out, 32'd101);
        repeat (7) cyc(0, 0, 1);
        check("empty_again", 32'(count), 32'd0);

        cyc(1, 1, 0); cyc(1, 2, 0);
        for (int k = 3; k <= 20; k++) begin
            cyc(1, word_t'(k), 1);
            check("stream_count", 32'(count), 32'd2);
        end
        repeat (2) cyc(0, 0, 1);

        for (int i = 0; i < 4; i++) cyc(1, word_t'(50 + i), 0);
        reset = 1'b1;
        cyc(1, 77, 1);
        reset = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", data_out, 32'd0);
        check("mid_rst_drop", 32'(drop_err), 32'd0);
        cyc(1, 42, 0);
        check("post_rst_head", data_out, 32'd42);
        check("post_rst_count", 32'(count), 32'd1);
        cyc(0, 0, 1);

        cyc(1, 9, 1);
        check("fwft_count", 32'(count), 32'd1);
        check("fwft_valid", 32'(out_valid), 32'd1);
        check("fwft_data", data_out, 32'd9);
        cyc(0, 0, 1);
        check("fwft_popped", 32'(count), 32'd0);

        for (int ph = 0; ph < 12; ph++) begin
            int p_in;
            int p_out;
            p_in  = $urandom_range(10, 95);
            p_out = $urandom_range(10, 95);
            for (int c = 0; c < 50; c++) begin
                reset = ($urandom_range(0, 99) == 0);
                cyc($urandom_range(0, 99) < p_in, $urandom, $urandom_range(0, 99) < p_out);
            end
        end
        reset = 1'b0;
        repeat (DEPTH + 2) cyc(0, 0, 1);
        check("final_count", 32'(count), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
